// File: rtl/ffq_pkg.sv
// Shared types and constants for the fastest-finger-first round controller.
// Holds the round state enum, result codes and a code-to-mask helper.
package ffq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOCKED,
        ST_DONE
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_CORRECT = 2'd1;
    localparam logic [1:0] RES_NOWIN   = 2'd2;

    localparam logic [3:0] CODE_NONE = 4'd0;

    // Contestant code k (1..15) maps to bit k-1; code 0 maps to no bit.
    function automatic logic [15:0] code_onehot(input logic [3:0] code);
        logic [15:0] r;
        r = '0;
        if (code != CODE_NONE) begin
            r[code - 4'd1] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ffq_tick_timer.sv
// Loadable tick down-counter used for the arm and answer windows.
// Ports: load/load_val reload, run+tick decrement, count, zero, expire (1->0).
module ffq_tick_timer #(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    input  logic              run,
    input  logic              tick,
    output logic [TICK_W-1:0] count,
    output logic              zero,
    output logic              expire
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    assign zero = (count == '0);

    // Excludes load on purpose: the controller chooses load based on expire.
    assign expire = run && tick && (count == ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && tick && !zero) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/ffq_round_ctrl.sv
// Round controller: latches first valid buzzer press, runs timers, judges.
// Ports: host pulses in, encoder code in; encoder_en, winner, mask, status out.
module ffq_round_ctrl
    import ffq_pkg::*;
#(
    parameter int N_CONTEST    = 10,
    parameter int TICK_W       = 8,
    parameter int ARM_TICKS    = 30,
    parameter int ANSWER_TICKS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 tick,
    input  logic                 judge_ok,
    input  logic                 judge_wrong,
    input  logic [3:0]           code_in,
    output logic                 encoder_en,
    output logic [3:0]           winner,
    output logic                 winner_valid,
    output logic [N_CONTEST-1:0] lockout_mask,
    output logic [TICK_W-1:0]    time_left,
    output logic                 round_over,
    output logic [1:0]           result
);

    if (N_CONTEST < 1 || N_CONTEST > 15) begin : g_bad_n
        $error("ffq_round_ctrl: N_CONTEST must be 1..15");
    end
    if (TICK_W < 1 || TICK_W > 31) begin : g_bad_w
        $error("ffq_round_ctrl: TICK_W must be 1..31");
    end
    if (ARM_TICKS < 1 || ARM_TICKS >= (1 << TICK_W)) begin : g_bad_arm
        $error("ffq_round_ctrl: ARM_TICKS must be nonzero and fit TICK_W");
    end
    if (ANSWER_TICKS < 1 || ANSWER_TICKS >= (1 << TICK_W)) begin : g_bad_ans
        $error("ffq_round_ctrl: ANSWER_TICKS must be nonzero and fit TICK_W");
    end

    localparam logic [TICK_W-1:0] ARM_LD = TICK_W'(ARM_TICKS);
    localparam logic [TICK_W-1:0] ANS_LD = TICK_W'(ANSWER_TICKS);
    localparam logic [3:0]        MAX_CODE = 4'(N_CONTEST);

    state_t state;
    state_t nxt_state;

    logic [3:0]           nxt_winner;
    logic                 nxt_wv;
    logic [N_CONTEST-1:0] nxt_mask;
    logic [1:0]           nxt_result;

    logic              tmr_load;
    logic [TICK_W-1:0] tmr_val;
    logic              tmr_run;
    logic              tmr_zero;
    logic              tmr_expire;

    logic [15:0]          code_oh_full;
    logic [15:0]          win_oh_full;
    logic [N_CONTEST-1:0] code_oh;
    logic [N_CONTEST-1:0] win_oh;
    logic                 code_ok;
    logic                 all_locked;

    assign code_oh_full = code_onehot(code_in);
    assign win_oh_full  = code_onehot(winner);
    assign code_oh      = code_oh_full[N_CONTEST-1:0];
    assign win_oh       = win_oh_full[N_CONTEST-1:0];

    assign code_ok = (code_in != CODE_NONE)
                   && (code_in <= MAX_CODE)
                   && ((code_oh & lockout_mask) == '0);

    assign all_locked = &(lockout_mask | win_oh);

    assign tmr_run = (state == ST_ARMED) || (state == ST_LOCKED);

    ffq_tick_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .tick     (tick),
        .count    (time_left),
        .zero     (tmr_zero),
        .expire   (tmr_expire)
    );

    always_comb begin
        nxt_state  = state;
        nxt_winner = winner;
        nxt_wv     = winner_valid;
        nxt_mask   = lockout_mask;
        nxt_result = result;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        if (clear) begin
            nxt_state  = ST_IDLE;
            nxt_winner = CODE_NONE;
            nxt_wv     = 1'b0;
            nxt_mask   = '0;
            nxt_result = RES_NONE;
            tmr_load   = 1'b1;
        end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
            nxt_state  = ST_ARMED;
            nxt_winner = CODE_NONE;
            nxt_wv     = 1'b0;
            nxt_mask   = '0;
            nxt_result = RES_NONE;
            tmr_load   = 1'b1;
            tmr_val    = ARM_LD;
        end else begin
            unique case (state)
                ST_ARMED: begin
                    if (code_ok) begin
                        nxt_state  = ST_LOCKED;
                        nxt_winner = code_in;
                        nxt_wv     = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = ANS_LD;
                    end else if (tmr_expire || tmr_zero) begin
                        // tmr_zero here is unreachable; it keeps ARMED
                        // from ever idling on a dead timer.
                        nxt_state  = ST_DONE;
                        nxt_result = RES_NOWIN;
                    end
                end
                ST_LOCKED: begin
                    if (judge_ok) begin
                        nxt_state  = ST_DONE;
                        nxt_wv     = 1'b0;
                        nxt_result = RES_CORRECT;
                        tmr_load   = 1'b1;
                    end else if (judge_wrong || tmr_expire) begin
                        nxt_mask = lockout_mask | win_oh;
                        nxt_wv   = 1'b0;
                        tmr_load = 1'b1;
                        if (all_locked) begin
                            nxt_state  = ST_DONE;
                            nxt_result = RES_NOWIN;
                        end else begin
                            nxt_state = ST_ARMED;
                            tmr_val   = ARM_LD;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            winner       <= CODE_NONE;
            winner_valid <= 1'b0;
            lockout_mask <= '0;
            result       <= RES_NONE;
            encoder_en   <= 1'b0;
            round_over   <= 1'b0;
        end else begin
            state        <= nxt_state;
            winner       <= nxt_winner;
            winner_valid <= nxt_wv;
            lockout_mask <= nxt_mask;
            result       <= nxt_result;
            encoder_en   <= (nxt_state == ST_ARMED);
            round_over   <= (nxt_state == ST_DONE);
        end
    end

endmodule

// File: doc/ffq_round_ctrl.md
Name: ffq_round_ctrl

Overview:
Round controller for the fastest-finger-first buzzer. Sits directly downstream of the 10-input priority encoder: it consumes the encoder's 4-bit contestant code (1..10, 0 = none) and drives the encoder enable. It latches the first valid press, locks out further presses, runs arm and answer timers, and applies host judgements. It also produces a per-contestant lockout mask that is ANDed with the button vector ahead of the encoder.

Parameters:
N_CONTEST, 10, number of contestants; contestant codes are 1..N_CONTEST.
TICK_W, 8, width of time_left and of the tick counters.
ARM_TICKS, 30, ticks allowed in ARMED with no press before the round times out.
ANSWER_TICKS, 10, ticks allowed for the locked contestant to answer.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  host pulse: arm a new round.
clear  in  1  host pulse: abort to IDLE.
tick  in  1  one-cycle timebase strobe, e.g. 1 Hz enable.
judge_ok  in  1  host pulse: locked contestant answered correctly.
judge_wrong  in  1  host pulse: locked contestant answered wrongly.
code_in  in  4  contestant code from the priority encoder.
encoder_en  out  1  enable to the priority encoder.
winner  out  4  latched contestant code.
winner_valid  out  1  high while a contestant holds the floor.
lockout_mask  out  N_CONTEST  bit i-1 set means contestant i is locked out.
time_left  out  TICK_W  remaining ticks of the active timer.
round_over  out  1  high in DONE.
result  out  2  0 = none, 1 = correct, 2 = no winner (timeout or all locked out).

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - All outputs go to 0: encoder_en, winner, winner_valid, lockout_mask, time_left, round_over, result.
  - Reset overrides every other input and applies even mid-round.
- States: IDLE, ARMED, LOCKED, DONE. All outputs are registered.
- Input priority, every state: clear > start > judge_ok > judge_wrong > code_in > tick.
- clear: go to IDLE; zero winner, winner_valid, lockout_mask, time_left, round_over and result.
- start, accepted in IDLE or DONE:
  - Go to ARMED; time_left <= ARM_TICKS; lockout_mask <= 0; result <= 0; winner <= 0.
  - start is ignored in ARMED and LOCKED.
- ARMED:
  - encoder_en = 1.
  - A code_in value in 1..N_CONTEST whose mask bit is clear is valid. On a valid code: winner <= code_in; winner_valid <= 1; time_left <= ANSWER_TICKS; go to LOCKED.
  - encoder_en drops on that same edge, so winner_valid rises one cycle after the code is sampled.
  - Codes 0, codes above N_CONTEST, and masked codes are ignored.
  - On tick with no valid code: time_left decrements. If time_left is 1 at that tick, it becomes 0, result <= 2, and the state goes to DONE.
  - A valid press in the same cycle as the expiring tick wins: go to LOCKED.
- LOCKED:
  - encoder_en = 0; code_in is ignored.
  - judge_ok: result <= 1; go to DONE; winner stays latched; winner_valid <= 0.
  - judge_wrong, or the expiring tick (time_left 1 -> 0): set lockout_mask[winner-1]; winner_valid <= 0.
    - If all N_CONTEST mask bits are now set: result <= 2; go to DONE.
    - Otherwise: time_left <= ARM_TICKS; go back to ARMED.
  - judge_ok and judge_wrong together: judge_ok wins. A judge pulse in the same cycle as a tick: the judge wins and the tick is dropped.
- DONE: round_over = 1; encoder_en = 0; time_left = 0; winner and result hold until start or clear.
- Timer arithmetic: time_left never wraps below 0. A parameter value of 0 is illegal and must be flagged by an elaboration-time check.

Decomposition:
- Shared package ffq_pkg holds:
  - state enum ST_IDLE, ST_ARMED, ST_LOCKED, ST_DONE;
  - result constants RES_NONE = 0, RES_CORRECT = 1, RES_NOWIN = 2;
  - CODE_NONE = 4'd0.
- One natural sub-module, ffq_tick_timer: loadable down-counter with tick enable, a zero flag, and an "expire" pulse on the 1 -> 0 transition. The FSM stays in the top module.

Test Plan:
1. Reset, then start, then code_in = 4 two cycles later -> next cycle winner = 4, winner_valid = 1, encoder_en = 0, time_left = 10.
2. From LOCKED(4), judge_wrong -> lockout_mask = 10'b0000001000, state ARMED, time_left = 30. Then code_in = 4 is ignored; code_in = 7 -> winner = 7.
3. Start, then 30 ticks with code_in = 0 -> round_over = 1, result = 2, time_left = 0. A valid press on the 30th tick edge instead gives LOCKED.
4. LOCKED(2), then 10 ticks with no judge -> bit 1 of lockout_mask set, back in ARMED. judge_ok and judge_wrong in the same cycle on a later contestant -> result = 1.
5. Wrong answers for all 10 contestants in turn -> lockout_mask = 10'h3FF, result = 2, DONE. code_in = 11..15 in ARMED is never latched.
6. rst_n low during LOCKED with judge_ok high -> all outputs 0, state IDLE next cycle. clear in ARMED -> IDLE. start during LOCKED -> no change.
